// File: rtl/mult_pkg.sv
// Shared widths and FSM state encoding for the product-table loader and its
// shift-add multiplier.
package mult_pkg;

  localparam int DEF_WA = 4;
  localparam int DEF_WB = 4;
  localparam int DEF_WC = DEF_WA + DEF_WB;
  localparam int DEF_AW = DEF_WA + DEF_WB;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] LOAD   = 3'd1;
  localparam logic [STATE_W-1:0] MUL    = 3'd2;
  localparam logic [STATE_W-1:0] WRITE  = 3'd3;
  localparam logic [STATE_W-1:0] VERIFY = 3'd4;
  localparam logic [STATE_W-1:0] DONE   = 3'd5;

endpackage

// File: rtl/shift_add_mul.sv
// Unsigned shift-add multiplier: load latches the operands, each step consumes
// one multiplier bit (LSB first); finished flags the step that is the last one.
module shift_add_mul
  import mult_pkg::*;
#(
  parameter int WA = DEF_WA,
  parameter int WB = DEF_WB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WA-1:0]    a,
  input  logic [WB-1:0]    b,
  output logic [WA+WB-1:0] acc,
  output logic             finished
);

  localparam int WC = WA + WB;
  localparam int CW = $clog2(WB + 1);

  logic [WC-1:0] mcand;
  logic [WB-1:0] mplier;
  logic [CW-1:0] bitCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      bitCnt <= '0;
    end else if (load) begin
      mcand  <= WC'(a);
      mplier <= b;
      acc    <= '0;
      bitCnt <= '0;
    end else if (step) begin
      // Shifting both operands replaces the variable A<<bitcnt with a fixed shift
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      bitCnt <= bitCnt + CW'(1);
    end
  end

  assign finished = (bitCnt == CW'(WB - 1));

endmodule

// File: rtl/mult_table_writer.sv
// Fills the product-lookup BRAM: for every address {A,B} writes A*B.
// Optional READBACK_VERIFY_EN adds a read-back sweep with sticky error capture.
module mult_table_writer
  import mult_pkg::*;
#(
  parameter int WA = DEF_WA,
  parameter int WB = DEF_WB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             bram_we,
  output logic [WA+WB-1:0] bram_addr,
  output logic [WA+WB-1:0] bram_din
`ifdef READBACK_VERIFY_EN
  ,
  input  logic [WA+WB-1:0] bram_dout,
  output logic             err,
  output logic [WA+WB-1:0] err_addr
`endif
);

  localparam int WC = WA + WB;
  localparam int AW = WA + WB;

  logic [STATE_W-1:0] state;
  logic [AW-1:0]      addr;
  logic [WC-1:0]      mulAcc;
  logic               mulFinished;
  logic               lastAddr;

  assign lastAddr = (addr == '1);

  shift_add_mul #(.WA(WA), .WB(WB)) uMul (
    .clk      (clk),
    .rst      (rst),
    .load     (state == LOAD),
    .step     (state == MUL),
    .a        (addr[AW-1:WB]),
    .b        (addr[WB-1:0]),
    .acc      (mulAcc),
    .finished (mulFinished)
  );

`ifdef READBACK_VERIFY_EN
  logic [AW-1:0] rdAddr;
  logic          rdValid;
  logic          vLast;
  logic [WC-1:0] expProd;
  logic          mismatch;

  // BRAM read data lags the address by one cycle, so check against rdAddr
  assign expProd  = WC'(rdAddr[AW-1:WB]) * WC'(rdAddr[WB-1:0]);
  assign mismatch = rdValid && (bram_dout != expProd);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
`ifdef READBACK_VERIFY_EN
      rdAddr   <= '0;
      rdValid  <= 1'b0;
      vLast    <= 1'b0;
      err      <= 1'b0;
      err_addr <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= LOAD;
            addr  <= '0;
`ifdef READBACK_VERIFY_EN
            err      <= 1'b0;
            err_addr <= '0;
`endif
          end
        end
        LOAD: state <= MUL;
        MUL: begin
          if (mulFinished) state <= WRITE;
        end
        WRITE: begin
          if (lastAddr) begin
`ifdef READBACK_VERIFY_EN
            state   <= VERIFY;
            addr    <= '0;
            rdValid <= 1'b0;
            vLast   <= 1'b0;
`else
            state <= DONE;
`endif
          end else begin
            addr  <= addr + AW'(1);
            state <= LOAD;
          end
        end
`ifdef READBACK_VERIFY_EN
        VERIFY: begin
          // One extra cycle after the last address drains the final read
          rdAddr  <= addr;
          rdValid <= ~vLast;
          if (vLast)         state <= DONE;
          else if (lastAddr) vLast <= 1'b1;
          else               addr  <= addr + AW'(1);
          if (mismatch && !err) begin
            err      <= 1'b1;
            err_addr <= rdAddr;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == LOAD) || (state == MUL) || (state == WRITE);
  assign done      = (state == DONE);
  assign bram_we   = (state == WRITE);
  assign bram_addr = addr;
  assign bram_din  = mulAcc;

endmodule

// File: tb/tb_mult_table_writer.sv
// Self-checking bench for mult_table_writer with a behavioural BRAM model.
module tb_mult_table_writer;

`ifdef READBACK_VERIFY_EN
  localparam int FILL_CYC = 256 * 6 + 257;
`else
  localparam int FILL_CYC = 256 * 6;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, bram_we;
  logic [7:0] bram_addr, bram_din;
`ifdef READBACK_VERIFY_EN
  logic [7:0] bramDout = 8'h00;
  logic       err;
  logic [7:0] err_addr;
`endif

  mult_table_writer #(.WA(4), .WB(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din)
`ifdef READBACK_VERIFY_EN
    ,
    .bram_dout (bramDout),
    .err       (err),
    .err_addr  (err_addr)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  int  weCount = 0;
  int  seqErr = 0;
  int  consecErr = 0;
  int  expAddr = 0;
  logic [7:0] lastWr = 8'h00;
  logic prevWe = 1'b0;
  logic corruptReq = 1'b0;

  // BRAM model and write-port monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'hAA;
      expAddr = 0;
      prevWe  = 1'b0;
    end else begin
      if (start && !busy) expAddr = 0;
      if (bram_we) begin
        mem[bram_addr] = bram_din;
        weCount++;
        if (int'(bram_addr) != expAddr) seqErr++;
        expAddr++;
        lastWr = bram_addr;
        if (corruptReq && bram_addr == 8'hFF) mem[8'hFB] = 8'h00;
        if (prevWe) consecErr++;
      end
      prevWe = bram_we;
    end
  end

`ifdef READBACK_VERIFY_EN
  always @(posedge clk) bramDout <= mem[bram_addr];
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns edges after the start edge until done; optionally pulses start meanwhile
  task automatic waitDone(input bit pulseStart, output int cyc, output int busyCyc);
    cyc = 0;
    busyCyc = 0;
    while (!done && cyc < 4000) begin
      if (pulseStart) start = ((cyc % 7) == 3);
      if (busy) busyCyc++;
      tick();
      cyc++;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] prod;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int cyc, busyCyc, wc0;

    vecs[0]  = '{8'hFF, 8'hE1};
    vecs[1]  = '{8'hFB, 8'hA5};
    vecs[2]  = '{8'hFA, 8'h96};
    vecs[3]  = '{8'hFE, 8'hD2};
    vecs[4]  = '{8'hF8, 8'h78};
    vecs[5]  = '{8'h00, 8'h00};
    vecs[6]  = '{8'h37, 8'h15};
    vecs[7]  = '{8'hA5, 8'h32};
    vecs[8]  = '{8'h1F, 8'h0F};
    vecs[9]  = '{8'hF1, 8'h0F};
    vecs[10] = '{8'h88, 8'h40};
    vecs[11] = '{8'hCD, 8'h9C};

    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_we",   32'(bram_we), 0);
    check("rst_addr", 32'(bram_addr), 0);
    check("rst_din",  32'(bram_din), 0);
    rst = 1'b0;
    tick();

    // Full fill and table contents
    wc0 = weCount;
    doStart();
    check("s1_busy_after_start", 32'(busy), 1);
    waitDone(1'b0, cyc, busyCyc);
    check("s1_fill_cycles", 32'(cyc), 32'(FILL_CYC));
    check("s1_busy_cycles", 32'(busyCyc), 32'(256 * 6));
    check("s1_done", 32'(done), 1);
    check("s1_busy_end", 32'(busy), 0);
    for (int i = 0; i < 12; i++)
      check($sformatf("s1_mem_%02h", vecs[i].addr), 32'(mem[vecs[i].addr]), 32'(vecs[i].prod));

    // Write-port discipline
    check("s2_we_count", 32'(weCount - wc0), 256);
    check("s2_seq_err", 32'(seqErr), 0);
    check("s2_consec_we", 32'(consecErr), 0);
    check("s2_last_addr", 32'(lastWr), 32'hFF);

    // Start in DONE restarts from address 0
    wc0 = weCount;
    doStart();
    check("s5_done_drop", 32'(done), 0);
    check("s5_addr0", 32'(bram_addr), 0);
    waitDone(1'b0, cyc, busyCyc);
    check("s5_fill_cycles", 32'(cyc), 32'(FILL_CYC));
    check("s5_done", 32'(done), 1);
    check("s5_we_count", 32'(weCount - wc0), 256);

    // Start pulses while busy are ignored
    wc0 = weCount;
    doStart();
    waitDone(1'b1, cyc, busyCyc);
    check("s3_fill_cycles", 32'(cyc), 32'(FILL_CYC));
    check("s3_we_count", 32'(weCount - wc0), 256);
    check("s3_seq_err", 32'(seqErr), 0);
    check("s3_consec_we", 32'(consecErr), 0);

    // Reset mid-fill, during the WRITE of entry 99
    doStart();
    repeat (599) tick();
    check("s4_we_before_rst", 32'(bram_we), 1);
    rst = 1'b1;
    #1;
    check("s4_we_rst", 32'(bram_we), 0);
    check("s4_busy_rst", 32'(busy), 0);
    check("s4_done_rst", 32'(done), 0);
    tick();
    rst = 1'b0;
    tick();
    check("s4_idle_busy", 32'(busy), 0);
    check("s4_idle_done", 32'(done), 0);
    check("s4_mem_ff_cleared", 32'(mem[8'hFF]), 32'hAA);
    wc0 = weCount;
    doStart();
    waitDone(1'b0, cyc, busyCyc);
    check("s4_fill_cycles", 32'(cyc), 32'(FILL_CYC));
    check("s4_mem_ff", 32'(mem[8'hFF]), 32'hE1);
    check("s4_we_count", 32'(weCount - wc0), 256);

`ifdef READBACK_VERIFY_EN
    check("s6_clean_err", 32'(err), 0);
    corruptReq = 1'b1;
    doStart();
    waitDone(1'b0, cyc, busyCyc);
    corruptReq = 1'b0;
    check("s6_done", 32'(done), 1);
    check("s6_err", 32'(err), 1);
    check("s6_err_addr", 32'(err_addr), 32'hFB);
    doStart();
    check("s6_err_cleared", 32'(err), 0);
    waitDone(1'b0, cyc, busyCyc);
    check("s6_clean_rerun_err", 32'(err), 0);
    check("s6_rerun_cycles", 32'(cyc), 32'(FILL_CYC));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
